// File: rtl/b_bus_seq_mux.sv
// b_bus_seq_mux: registered bus multiplexer with single-transfer and
// incrementing-burst sources, valid/ready backpressure and error pulses.
// Optional feature macro: BBUS_PARITY_EN adds a registered even-parity
// bit aligned with bus_out; without it bus_par is tied low.
module b_bus_seq_mux #(
   parameter int DATA_W = 32,
   parameter int NSRC   = 20,
   parameter int SEL_W  = 5,
   parameter int LEN_W  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NSRC*DATA_W-1:0] src,
   input  logic [SEL_W-1:0]       sel,
   input  logic                   sel_valid,
   input  logic                   burst_start,
   input  logic [SEL_W-1:0]       burst_base,
   input  logic [LEN_W-1:0]       burst_len,
   input  logic                   bus_ready,
   output logic [DATA_W-1:0]      bus_out,
   output logic                   bus_valid,
   output logic                   bus_par,
   output logic                   busy,
   output logic                   burst_done,
   output logic                   err
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   localparam logic [SEL_W:0] NSRC_C = (SEL_W+1)'(NSRC);
   localparam logic [SEL_W:0] LAST_C = (SEL_W+1)'(NSRC - 1);

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    ptr_q, ptr_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [DATA_W-1:0]   bus_out_q, bus_out_d;
   logic                bus_valid_q, bus_valid_d;
   logic                burst_done_q, burst_done_d;
   logic                err_q, err_d;

   logic                ld;
   logic                do_load;
   logic                err_req;
   logic                idx_bad;
   logic [SEL_W-1:0]    load_idx;
   logic [DATA_W-1:0]   load_word;

   // Out-of-range indices match no source and therefore select zero.
   function automatic logic [DATA_W-1:0] pick(input logic [NSRC*DATA_W-1:0] s,
                                              input logic [SEL_W-1:0]       idx);
      logic [DATA_W-1:0] w;
      w = '0;
      for (int n = 0; n < NSRC; n++) begin
         if (idx == SEL_W'(n)) w = s[n*DATA_W +: DATA_W];
      end
      return w;
   endfunction

   // Pointer increment wrapping from the last source back to source 0.
   function automatic logic [SEL_W-1:0] ptr_inc(input logic [SEL_W-1:0] p);
      if ({1'b0, p} >= LAST_C) return '0;
      return p + SEL_W'(1);
   endfunction

   assign ld   = !bus_valid_q | bus_ready;
   assign busy = (state_q == ST_BURST) | !ld;

   // Control: request arbitration, burst sequencing and next-state logic.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d      = state_q;
      ptr_d        = ptr_q;
      rem_d        = rem_q;
      bus_valid_d  = bus_valid_q;
      burst_done_d = 1'b0;
      err_req      = 1'b0;
      do_load      = 1'b0;
      load_idx     = '0;
      if (ld) begin
         unique case (state_q)
            ST_BURST: begin
               do_load  = 1'b1;
               load_idx = ptr_q;
               ptr_d    = ptr_inc(ptr_q);
               rem_d    = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d      = ST_IDLE;
                  burst_done_d = 1'b1;
               end
            end
            default: begin
               if (burst_start) begin
                  if (burst_len == '0) begin
                     err_req     = 1'b1;
                     bus_valid_d = 1'b0;
                  end else begin
                     do_load  = 1'b1;
                     load_idx = burst_base;
                     ptr_d    = ptr_inc(burst_base);
                     rem_d    = burst_len - LEN_W'(1);
                     if (burst_len == LEN_W'(1)) burst_done_d = 1'b1;
                     else                        state_d      = ST_BURST;
                  end
               end else if (sel_valid) begin
                  do_load  = 1'b1;
                  load_idx = sel;
               end else begin
                  bus_valid_d = 1'b0;
               end
            end
         endcase
      end
      if (do_load) bus_valid_d = 1'b1;
   end

   // Datapath: source selection, range check and bus word update.
   always_comb begin
      idx_bad   = ({1'b0, load_idx} >= NSRC_C);
      load_word = pick(src, load_idx);
      bus_out_d = do_load ? load_word : bus_out_q;
      err_d     = err_req | (do_load & idx_bad);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         rem_q        <= '0;
         bus_out_q    <= '0;
         bus_valid_q  <= 1'b0;
         burst_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         rem_q        <= rem_d;
         bus_out_q    <= bus_out_d;
         bus_valid_q  <= bus_valid_d;
         burst_done_q <= burst_done_d;
         err_q        <= err_d;
      end
   end

`ifdef BBUS_PARITY_EN
   logic bus_par_q, bus_par_d;

   // Parity of the word being loaded, held alongside bus_out.
   always_comb begin
      bus_par_d = do_load ? ^load_word : bus_par_q;
   end

   // Parity register, cleared with the rest of the outputs.
   always_ff @(posedge clk) begin
      if (rst) bus_par_q <= 1'b0;
      else     bus_par_q <= bus_par_d;
   end

   assign bus_par = bus_par_q;
`else
   assign bus_par = 1'b0;
`endif

   assign bus_out    = bus_out_q;
   assign bus_valid  = bus_valid_q;
   assign burst_done = burst_done_q;
   assign err        = err_q;

endmodule
